// File: rtl/shared_track_arbiter.sv
// Round-robin interlock for NUM_TRAINS trains sharing one track section.
// It grants the section, holds it through clearance, and latches an occupancy-timeout fault.
module shared_track_arbiter #(
  parameter int NUM_TRAINS   = 4,
  parameter int CLEAR_CYCLES = 3,
  parameter int TIMEOUT      = 255,
  parameter int SELW         = (NUM_TRAINS > 1) ? $clog2(NUM_TRAINS) : 1
) (
  input  logic                    Clock,
  input  logic                    RESET,
  input  logic [NUM_TRAINS-1:0]   SR_APPROACH,
  input  logic [NUM_TRAINS-1:0]   SR_EXIT,
  input  logic                    FAULT_CLR,
  output logic [SELW-1:0]         SW_SEL,
  output logic                    SW_VALID,
  output logic [2*NUM_TRAINS-1:0] DA,
  output logic                    BUSY,
  output logic                    FAULT
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  localparam logic [TW-1:0]   TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0]   TMR_MAX  = {TW{1'b1}};
  localparam logic [CW-1:0]   CLR_LAST = CW'(CLEAR_CYCLES - 1);
  localparam logic [SELW-1:0] LAST_IDX = SELW'(NUM_TRAINS - 1);
  localparam logic [1:0]      DA_GO    = 2'b01;
  localparam logic [1:0]      DA_STOP  = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_CLEAR = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [SELW-1:0]         owner_q, owner_d;
  logic [SELW-1:0]         ptr_q, ptr_d;
  logic [SELW-1:0]         winner_s;
  logic [TW-1:0]           timer_q, timer_d;
  logic [CW-1:0]           clr_q, clr_d;
  logic                    sw_valid_q, sw_valid_d;
  logic                    busy_q, busy_d;
  logic                    fault_q, fault_d;
  logic [2*NUM_TRAINS-1:0] da_q, da_d;

  // Scanning from the far end lets the nearest requester at/after the pointer win.
  always_comb begin
    logic [SELW:0]   sum;
    logic [SELW-1:0] idx;
    winner_s = ptr_q;
    sum      = {(SELW+1){1'b0}};
    idx      = {SELW{1'b0}};
    for (int k = NUM_TRAINS - 1; k >= 0; k--) begin
      sum      = {1'b0, ptr_q} + (SELW+1)'(k);
      idx      = (sum >= (SELW+1)'(NUM_TRAINS)) ? SELW'(sum - (SELW+1)'(NUM_TRAINS)) : SELW'(sum);
      winner_s = SR_APPROACH[idx] ? idx : winner_s;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    clr_d   = clr_q;
    case (state_q)
      S_IDLE: begin
        if (|SR_APPROACH) begin
          state_d = S_GRANT;
          owner_d = winner_s;
          ptr_d   = (winner_s == LAST_IDX) ? {SELW{1'b0}} : winner_s + SELW'(1);
          timer_d = {TW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        // An owner exit outranks a timeout expiring on the same edge.
        if (SR_EXIT[owner_q]) begin
          state_d = S_CLEAR;
          timer_d = {TW{1'b0}};
          clr_d   = {CW{1'b0}};
        end else if ((TIMEOUT > 0) && (timer_q == TMO_LAST)) begin
          state_d = S_FAULT;
        end else if (timer_q != TMR_MAX) begin
          timer_d = timer_q + TW'(1);
        end else begin
          timer_d = timer_q;
        end
      end
      S_CLEAR: begin
        if (clr_q == CLR_LAST) begin
          state_d = S_IDLE;
        end else begin
          clr_d = clr_q + CW'(1);
        end
      end
      S_FAULT: begin
        if (FAULT_CLR) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FAULT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are derived from the next state so they register on the same edge.
  always_comb begin
    sw_valid_d = (state_d == S_GRANT) || (state_d == S_CLEAR);
    busy_d     = (state_d == S_GRANT) || (state_d == S_CLEAR);
    fault_d    = (state_d == S_FAULT);
    da_d       = {NUM_TRAINS{DA_GO}};
    for (int i = 0; i < NUM_TRAINS; i++) begin
      if (state_d == S_FAULT) begin
        da_d[2*i +: 2] = DA_STOP;
      end else if (owner_d == SELW'(i)) begin
        da_d[2*i +: 2] = DA_GO;
      end else if (SR_APPROACH[i]) begin
        da_d[2*i +: 2] = DA_STOP;
      end else begin
        da_d[2*i +: 2] = DA_GO;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      owner_q    <= {SELW{1'b0}};
      ptr_q      <= {SELW{1'b0}};
      timer_q    <= {TW{1'b0}};
      clr_q      <= {CW{1'b0}};
      sw_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
      da_q       <= {NUM_TRAINS{DA_GO}};
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      timer_q    <= timer_d;
      clr_q      <= clr_d;
      sw_valid_q <= sw_valid_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
      da_q       <= da_d;
    end
  end

  // The switch always points at the most recent owner.
  assign SW_SEL   = owner_q;
  assign SW_VALID = sw_valid_q;
  assign DA       = da_q;
  assign BUSY     = busy_q;
  assign FAULT    = fault_q;

endmodule

// File: tb/tb_shared_track_arbiter.sv
// Directed plus randomized bench for shared_track_arbiter (4 trains, clear 3, timeout 16),
// checked against a cycle-level behavioural model of the interlock rules.
module tb_shared_track_arbiter;

  localparam int N   = 4;
  localparam int CLR = 3;
  localparam int TMO = 16;

  logic         Clock = 1'b0;
  logic         RESET;
  logic [N-1:0] SR_APPROACH;
  logic [N-1:0] SR_EXIT;
  logic         FAULT_CLR;
  logic [1:0]   SW_SEL;
  logic         SW_VALID;
  logic [7:0]   DA;
  logic         BUSY;
  logic         FAULT;

  int vectors     = 0;
  int miscompares = 0;

  // Model: mode 0 idle, 1 granted, 2 clearing, 3 faulted.
  int          m_mode;
  int          m_owner;
  int          m_ptr;
  int          m_age;
  int          m_left;
  logic [12:0] m_exp;

  int ord [4] = '{0, 1, 3, 0};

  shared_track_arbiter #(
    .NUM_TRAINS  (N),
    .CLEAR_CYCLES(CLR),
    .TIMEOUT     (TMO)
  ) dut (
    .Clock      (Clock),
    .RESET      (RESET),
    .SR_APPROACH(SR_APPROACH),
    .SR_EXIT    (SR_EXIT),
    .FAULT_CLR  (FAULT_CLR),
    .SW_SEL     (SW_SEL),
    .SW_VALID   (SW_VALID),
    .DA         (DA),
    .BUSY       (BUSY),
    .FAULT      (FAULT)
  );

  always #5 Clock = ~Clock;

  function automatic bit bit_of(input logic [3:0] v, input int i);
    logic [3:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [12:0] obs();
    return {SW_SEL, SW_VALID, DA, BUSY, FAULT};
  endfunction

  function automatic logic [12:0] pk(input logic [1:0] sel, input logic vld,
                                     input logic [7:0] da, input logic bsy, input logic flt);
    return {sel, vld, da, bsy, flt};
  endfunction

  task automatic model_step(input logic rst, input logic [3:0] ap, input logic [3:0] ex,
                            input logic fc);
    logic [7:0] da;
    if (rst) begin
      m_mode = 0; m_owner = 0; m_ptr = 0; m_age = 0; m_left = 0;
    end else begin
      case (m_mode)
        0: if (ap != 4'b0000) begin
             for (int k = 0; k < N; k++) begin
               if (bit_of(ap, (m_ptr + k) % N)) begin
                 m_owner = (m_ptr + k) % N;
                 break;
               end
             end
             m_ptr  = (m_owner + 1) % N;
             m_mode = 1;
             m_age  = 0;
           end
        1: begin
             m_age++;
             if (bit_of(ex, m_owner)) begin
               m_mode = 2;
               m_left = CLR;
             end else if (m_age >= TMO) begin
               m_mode = 3;
             end
           end
        2: begin
             m_left--;
             if (m_left == 0) m_mode = 0;
           end
        3: if (fc) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
    for (int i = 0; i < N; i++) begin
      if (m_mode == 3)          da[2*i +: 2] = 2'b00;
      else if (i == m_owner)    da[2*i +: 2] = 2'b01;
      else if (bit_of(ap, i))   da[2*i +: 2] = 2'b00;
      else                      da[2*i +: 2] = 2'b01;
    end
    if (rst) da = 8'h55;
    m_exp = {2'(m_owner), (m_mode == 1 || m_mode == 2), da, (m_mode == 1 || m_mode == 2),
             (m_mode == 3)};
  endtask

  task automatic tick(input logic rst, input logic [3:0] ap, input logic [3:0] ex,
                      input logic fc);
    RESET       = rst;
    SR_APPROACH = ap;
    SR_EXIT     = ex;
    FAULT_CLR   = fc;
    @(posedge Clock);
    model_step(rst, ap, ex, fc);
    #1;
    vectors++;
    assert (obs() === m_exp) else begin
      miscompares++;
      $error("FAIL model obs=%h exp=%h", obs(), m_exp);
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s obs=%h exp=%h", tag, o, e);
    end
  endtask

  initial begin
    RESET = 1'b1; SR_APPROACH = 4'b0000; SR_EXIT = 4'b0000; FAULT_CLR = 1'b0;
    m_mode = 0; m_owner = 0; m_ptr = 0; m_age = 0; m_left = 0; m_exp = 13'd0;

    // 1: reset with random inputs
    tick(1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
    tick(1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
    chk("reset", obs(), pk(2'd0, 1'b0, 8'h55, 1'b0, 1'b0));

    // 2: single train 2, exit after 5 cycles, 3 clear cycles
    tick(1'b0, 4'b0100, 4'b0000, 1'b0);
    chk("t2_grant", obs(), pk(2'd2, 1'b1, 8'h55, 1'b1, 1'b0));
    repeat (4) tick(1'b0, 4'b0100, 4'b0000, 1'b0);
    tick(1'b0, 4'b0100, 4'b0100, 1'b0);
    chk("t2_clear", {SW_VALID, BUSY}, 2'b11);
    repeat (CLR - 1) begin
      tick(1'b0, 4'b0000, 4'b0000, 1'b0);
      chk("t2_clear", {SW_VALID, BUSY}, 2'b11);
    end
    tick(1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("t2_idle", {SW_VALID, BUSY}, 2'b00);

    // 3: round-robin order with 1011 held
    tick(1'b1, 4'b1011, 4'b0000, 1'b0);
    for (int g = 0; g < 4; g++) begin
      tick(1'b0, 4'b1011, 4'b0000, 1'b0);
      chk("t3_order", 16'(SW_SEL), 16'(ord[g]));
      if (g == 0) chk("t3_da", 16'(DA), 16'h0011);
      tick(1'b0, 4'b1011, 4'b0000, 1'b0);
      tick(1'b0, 4'b1011, 4'(1 << ord[g]), 1'b0);
      repeat (CLR) tick(1'b0, 4'b1011, 4'b0000, 1'b0);
    end

    // 4: train 1 times out, then fault recovery
    tick(1'b0, 4'b0010, 4'b0000, 1'b0);
    chk("t4_grant", 16'(SW_SEL), 16'd1);
    for (int c = 1; c <= TMO; c++) begin
      chk("t4_nofault", 16'(FAULT), 16'd0);
      tick(1'b0, 4'b0000, 4'b0000, 1'b0);
    end
    chk("t4_fault", obs(), pk(2'd1, 1'b0, 8'h00, 1'b0, 1'b1));
    tick(1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("t4_fault_held", 16'(FAULT), 16'd1);
    tick(1'b0, 4'b0000, 4'b0000, 1'b1);
    chk("t4_recover", obs(), pk(2'd1, 1'b0, 8'h55, 1'b0, 1'b0));

    // 5: train 3, foreign exit ignored, owner exit on the timeout cycle wins
    tick(1'b0, 4'b1000, 4'b0000, 1'b0);
    chk("t5_grant", 16'(SW_SEL), 16'd3);
    for (int c = 1; c < TMO; c++) begin
      tick(1'b0, 4'b0000, 4'(c == 5), 1'b0);
      chk("t5_hold", {SW_SEL, BUSY, FAULT}, {2'd3, 1'b1, 1'b0});
    end
    tick(1'b0, 4'b0000, 4'b1000, 1'b0);
    chk("t5_clear", {SW_VALID, BUSY, FAULT}, 3'b110);
    repeat (CLR) tick(1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("t5_idle", {BUSY, FAULT}, 2'b00);

    // 6: reset during clear restarts the pointer
    tick(1'b0, 4'b0010, 4'b0000, 1'b0);
    tick(1'b0, 4'b0000, 4'b0010, 1'b0);
    tick(1'b1, 4'b1010, 4'b0000, 1'b0);
    chk("t6_reset", obs(), pk(2'd0, 1'b0, 8'h55, 1'b0, 1'b0));
    tick(1'b0, 4'b1010, 4'b0000, 1'b0);
    chk("t6_grant", obs(), pk(2'd1, 1'b1, 8'h15, 1'b1, 1'b0));

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      logic [3:0] ap;
      logic [3:0] ex;
      logic       f;
      logic       r;
      ap = 4'($urandom) & 4'($urandom);
      ex = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      f  = ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 99) == 0);
      tick(r, ap, ex, f);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
